// File: rtl/enc_3b4b_stream_ctrl_if.sv
// Stream, encoder and output-packer signals of the 3b4b stream sequencer.
// The slave modport is the sequencer; the master modport is its surroundings.
interface enc_3b4b_stream_ctrl_if;
  logic       i_in_valid;
  logic [7:0] i_in_data;
  logic       i_in_last;
  logic       o_in_ready;
  logic [2:0] o_enc_data;
  logic       o_enc_rd_in;
  logic       o_enc_enb;
  logic [3:0] i_enc_data;
  logic       i_enc_rd_out;
  logic       i_enc_valid;
  logic       o_out_valid;
  logic [7:0] o_out_data;
  logic       o_out_last;
  logic       i_out_ready;

  modport slave (
    input  i_in_valid, i_in_data, i_in_last, i_enc_data, i_enc_rd_out, i_enc_valid, i_out_ready,
    output o_in_ready, o_enc_data, o_enc_rd_in, o_enc_enb, o_out_valid, o_out_data, o_out_last
  );

  modport master (
    output i_in_valid, i_in_data, i_in_last, i_enc_data, i_enc_rd_out, i_enc_valid, i_out_ready,
    input  o_in_ready, o_enc_data, o_enc_rd_in, o_enc_enb, o_out_valid, o_out_data, o_out_last
  );
endinterface

// File: rtl/enc_3b4b_stream_ctrl.sv
// Packet sequencer feeding a 1-cycle 3b4b encoder: per-packet running disparity,
// credit-protected output FIFO with last-symbol tag, and packet length report.
module enc_3b4b_stream_ctrl #(
  parameter int PACKET_SIZE_WIDTH = 16,
  parameter int OUT_DEPTH         = 4
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  enc_3b4b_stream_ctrl_if.slave        bus,
  output logic [PACKET_SIZE_WIDTH-1:0] o_pkt_len,
  output logic                         o_pkt_done,
  output logic                         o_busy,
  output logic                         o_err_overlen
);
  localparam int PTR_W = $clog2(OUT_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_t;

  state_t                 state_q, state_d;
  logic                   first_q, first_d;
  logic                   in_flight_q, in_flight_d;
  logic                   last_tag_q, last_tag_d;
  logic                   rd_q, rd_d;
  logic                   err_q, err_d;
  logic [PACKET_SIZE_WIDTH-1:0] pkt_cnt_q, pkt_cnt_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       fifo_cnt_q, fifo_cnt_d;
  logic [4:0]             mem_q [OUT_DEPTH];
  logic [4:0]             mem_d [OUT_DEPTH];

  logic       in_ready, enb, fifo_wr, fifo_rd, out_valid, credit_ok, rd_fwd;
  logic [4:0] head;
  logic [CNT_W:0] credit_sum;
  logic       unused_in_bits;

  assign unused_in_bits = ^bus.i_in_data[7:3];

  // Encoder results only count when we actually issued the cycle before;
  // this also drops stale encoder output right after reset.
  assign fifo_wr    = bus.i_enc_valid & in_flight_q;
  assign out_valid  = (fifo_cnt_q != '0);
  assign fifo_rd    = out_valid & bus.i_out_ready;
  assign head       = mem_q[rd_ptr_q];
  assign credit_sum = {1'b0, fifo_cnt_q} + (CNT_W+1)'(in_flight_q);
  assign credit_ok  = credit_sum < (CNT_W+1)'(OUT_DEPTH);
  assign enb        = bus.i_in_valid & in_ready;
  assign rd_fwd     = first_q ? 1'b0 : (fifo_wr ? bus.i_enc_rd_out : rd_q);

  always_comb begin
    state_d     = state_q;
    first_d     = first_q;
    err_d       = err_q;
    pkt_cnt_d   = pkt_cnt_q;
    in_ready    = 1'b0;
    o_pkt_done  = 1'b0;
    in_flight_d = enb;
    last_tag_d  = enb & bus.i_in_last;
    rd_d        = fifo_wr ? bus.i_enc_rd_out : rd_q;

    if (fifo_wr) begin
      if (&pkt_cnt_q) err_d = 1'b1;
      else            pkt_cnt_d = pkt_cnt_q + PACKET_SIZE_WIDTH'(1);
    end

    case (state_q)
      ST_IDLE: begin
        pkt_cnt_d = '0;
        if (bus.i_in_valid) begin
          state_d = ST_RUN;
          first_d = 1'b1;
          err_d   = 1'b0;
        end
      end
      ST_RUN: begin
        in_ready = credit_ok;
        if (enb) first_d = 1'b0;
        if (enb && bus.i_in_last) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (fifo_rd && head[4]) state_d = ST_DONE;
      end
      ST_DONE: begin
        o_pkt_done = 1'b1;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    if (fifo_wr) begin
      mem_d[wr_ptr_q] = {last_tag_q, bus.i_enc_data};
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (fifo_rd) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    fifo_cnt_d = fifo_cnt_q + CNT_W'(fifo_wr) - CNT_W'(fifo_rd);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      first_q     <= 1'b0;
      in_flight_q <= 1'b0;
      last_tag_q  <= 1'b0;
      rd_q        <= 1'b0;
      err_q       <= 1'b0;
      pkt_cnt_q   <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fifo_cnt_q  <= '0;
      mem_q       <= '{default: '0};
    end else begin
      state_q     <= state_d;
      first_q     <= first_d;
      in_flight_q <= in_flight_d;
      last_tag_q  <= last_tag_d;
      rd_q        <= rd_d;
      err_q       <= err_d;
      pkt_cnt_q   <= pkt_cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fifo_cnt_q  <= fifo_cnt_d;
      mem_q       <= mem_d;
    end
  end

  assign bus.o_in_ready  = in_ready;
  assign bus.o_enc_enb   = enb;
  assign bus.o_enc_data  = enb ? bus.i_in_data[2:0] : 3'b000;
  assign bus.o_enc_rd_in = enb & rd_fwd;
  assign bus.o_out_valid = out_valid;
  assign bus.o_out_data  = out_valid ? {4'b0000, head[3:0]} : 8'h00;
  assign bus.o_out_last  = out_valid & head[4];

  assign o_pkt_len     = (state_q == ST_DONE) ? pkt_cnt_q : '0;
  assign o_busy        = (state_q != ST_IDLE);
  assign o_err_overlen = err_q;
endmodule

// File: tb/tb_enc_3b4b_stream_ctrl.sv
// Directed bench for enc_3b4b_stream_ctrl with a 1-cycle 3b4b encoder model;
// a second instance with a 3-bit symbol counter shares the stimulus.
module tb_enc_3b4b_stream_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  enc_3b4b_stream_ctrl_if if_a ();
  enc_3b4b_stream_ctrl_if if_b ();

  logic [15:0] len_a;
  logic        done_a, busy_a, err_a;
  logic [2:0]  len_b;
  logic        done_b, busy_b, err_b;

  enc_3b4b_stream_ctrl #(.PACKET_SIZE_WIDTH(16), .OUT_DEPTH(4)) dut_a (
    .i_clk(clk), .i_rst(rst), .bus(if_a),
    .o_pkt_len(len_a), .o_pkt_done(done_a), .o_busy(busy_a), .o_err_overlen(err_a)
  );

  enc_3b4b_stream_ctrl #(.PACKET_SIZE_WIDTH(3), .OUT_DEPTH(4)) dut_b (
    .i_clk(clk), .i_rst(rst), .bus(if_b),
    .o_pkt_len(len_b), .o_pkt_done(done_b), .o_busy(busy_b), .o_err_overlen(err_b)
  );

  // Encoder stand-in: standard 3b4b table, rd=0 means RD-.
  logic       enc_v = 1'b0;
  logic [3:0] enc_sym = 4'h0;
  logic       enc_rdo = 1'b0;

  function automatic logic [4:0] enc_3b4b(input logic [2:0] d, input logic rd);
    logic [4:0] r;
    case (d)
      3'd0:    r = rd ? {1'b0, 4'b0100} : {1'b1, 4'b1011};
      3'd1:    r = {rd, 4'b1001};
      3'd2:    r = {rd, 4'b0101};
      3'd3:    r = rd ? {1'b1, 4'b0011} : {1'b0, 4'b1100};
      3'd4:    r = rd ? {1'b0, 4'b0010} : {1'b1, 4'b1101};
      3'd5:    r = {rd, 4'b1010};
      3'd6:    r = {rd, 4'b0110};
      default: r = rd ? {1'b0, 4'b0001} : {1'b1, 4'b1110};
    endcase
    return r;
  endfunction

  always @(posedge clk) begin
    enc_v <= if_a.o_enc_enb;
    if (if_a.o_enc_enb) {enc_rdo, enc_sym} <= enc_3b4b(if_a.o_enc_data, if_a.o_enc_rd_in);
  end

  assign if_a.i_enc_valid  = enc_v;
  assign if_a.i_enc_data   = enc_sym;
  assign if_a.i_enc_rd_out = enc_rdo;

  assign if_b.i_in_valid   = if_a.i_in_valid;
  assign if_b.i_in_data    = if_a.i_in_data;
  assign if_b.i_in_last    = if_a.i_in_last;
  assign if_b.i_enc_valid  = if_a.i_enc_valid;
  assign if_b.i_enc_data   = if_a.i_enc_data;
  assign if_b.i_enc_rd_out = if_a.i_enc_rd_out;
  assign if_b.i_out_ready  = if_a.i_out_ready;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  logic [31:0] rx_sym [$];
  logic [31:0] rx_last[$];
  int          rx_cyc [$];
  logic [31:0] rd_log [$];
  logic [31:0] lena_q [$];
  logic [31:0] lenb_q [$];
  int          cyc = 0;
  int          acc_cnt = 0;
  int          wr_seen = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst) begin
      if (if_a.o_out_valid && if_a.i_out_ready) begin
        rx_sym.push_back(32'(if_a.o_out_data));
        rx_last.push_back(32'(if_a.o_out_last));
        rx_cyc.push_back(cyc);
      end
      if (if_a.o_enc_enb) begin
        rd_log.push_back(32'(if_a.o_enc_rd_in));
        acc_cnt <= acc_cnt + 1;
      end
      if (done_a) begin
        lena_q.push_back(32'(len_a));
        lenb_q.push_back(32'(len_b));
      end
      if (enc_v) wr_seen <= wr_seen + 1;
      if (dut_a.fifo_wr) check_eq("fifo_wr_when_full", 32'(dut_a.fifo_cnt_q), 32'(dut_a.fifo_cnt_q == 3'd4 ? 5 : dut_a.fifo_cnt_q));
    end
  end

  logic [7:0]  pkt_data[16];
  logic [31:0] exp_sym [16];
  logic [31:0] exp_rd  [16];

  task automatic clear_logs();
    rx_sym.delete(); rx_last.delete(); rx_cyc.delete(); rd_log.delete();
    lena_q.delete(); lenb_q.delete();
    acc_cnt = 0;
    wr_seen = 0;
  endtask

  task automatic send_pkt(input int n);
    for (int i = 0; i < n; i++) begin
      logic acc;
      int   t;
      if_a.i_in_valid = 1'b1;
      if_a.i_in_data  = pkt_data[i];
      if_a.i_in_last  = (i == n - 1);
      acc = 1'b0;
      t   = 0;
      while (!acc && t < 200) begin
        #1;
        acc = if_a.o_in_ready;
        @(negedge clk);
        t++;
      end
      if (!acc) check_eq("beat_accept_timeout", 32'(i), 32'(n));
    end
    if_a.i_in_valid = 1'b0;
    if_a.i_in_last  = 1'b0;
  endtask

  task automatic wait_done(input int n);
    int t;
    t = 0;
    while (lena_q.size() < n && t < 300) begin
      @(negedge clk);
      t++;
    end
    check_eq("pkt_done_seen", 32'(lena_q.size()), 32'(n));
  endtask

  task automatic check_syms(input string tag, input int n, input int last_idx);
    check_eq({tag, "_count"}, 32'(rx_sym.size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      check_eq({tag, "_sym"},  (i < rx_sym.size())  ? rx_sym[i]  : 32'hFFFF_FFFF, exp_sym[i]);
      check_eq({tag, "_last"}, (i < rx_last.size()) ? rx_last[i] : 32'hFFFF_FFFF,
               32'((i == last_idx) || (i == n - 1)));
    end
  endtask

  initial begin
    rst = 1'b1;
    if_a.i_in_valid  = 1'b0;
    if_a.i_in_data   = 8'h00;
    if_a.i_in_last   = 1'b0;
    if_a.i_out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst_outputs",
             32'({if_a.o_in_ready, if_a.o_enc_enb, if_a.o_out_valid, if_a.o_out_data,
                  if_a.o_out_last, done_a, len_a, busy_a, err_a}), 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Single packet 0..7, continuous drain
    clear_logs();
    for (int i = 0; i < 8; i++) pkt_data[i] = 8'(8'h08 * i + i);
    exp_sym[0:7] = '{32'hB, 32'h9, 32'h5, 32'h3, 32'h2, 32'hA, 32'h6, 32'hE};
    exp_rd[0:7]  = '{32'd0, 32'd1, 32'd1, 32'd1, 32'd1, 32'd0, 32'd0, 32'd0};
    send_pkt(8);
    wait_done(1);
    check_syms("p8", 8, -1);
    for (int i = 0; i < 8; i++)
      check_eq("p8_rd_in", (i < rd_log.size()) ? rd_log[i] : 32'hFFFF_FFFF, exp_rd[i]);
    check_eq("p8_len", (lena_q.size() > 0) ? lena_q[0] : 32'hFFFF_FFFF, 32'd8);
    check_eq("p8_no_gaps", (rx_cyc.size() == 8) ? 32'(rx_cyc[7] - rx_cyc[0]) : 32'hFFFF_FFFF, 32'd7);

    // Back-to-back 3-beat and 2-beat packets
    clear_logs();
    pkt_data[0] = 8'h00; pkt_data[1] = 8'h08; pkt_data[2] = 8'hF0;
    send_pkt(3);
    pkt_data[0] = 8'h04; pkt_data[1] = 8'hFC;
    send_pkt(2);
    wait_done(2);
    exp_sym[0:4] = '{32'hB, 32'h4, 32'hB, 32'hD, 32'h2};
    exp_rd[0:4]  = '{32'd0, 32'd1, 32'd0, 32'd0, 32'd1};
    check_syms("b2b", 5, 2);
    for (int i = 0; i < 5; i++)
      check_eq("b2b_rd_in", (i < rd_log.size()) ? rd_log[i] : 32'hFFFF_FFFF, exp_rd[i]);
    check_eq("b2b_len0", (lena_q.size() > 0) ? lena_q[0] : 32'hFFFF_FFFF, 32'd3);
    check_eq("b2b_len1", (lena_q.size() > 1) ? lena_q[1] : 32'hFFFF_FFFF, 32'd2);

    // Backpressure mid-packet
    clear_logs();
    for (int i = 0; i < 12; i++) pkt_data[i] = 8'(i % 8);
    exp_sym[0:11] = '{32'hB, 32'h9, 32'h5, 32'h3, 32'h2, 32'hA, 32'h6, 32'hE,
                      32'h4, 32'h9, 32'h5, 32'hC};
    fork
      send_pkt(12);
      begin
        int t;
        t = 0;
        while (rx_sym.size() < 3 && t < 100) begin
          @(negedge clk);
          t++;
        end
        if_a.i_out_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
          @(negedge clk);
          if (c == 2 || c == 9) begin
            check_eq("bp_hold_valid", 32'(if_a.o_out_valid), 32'd1);
            check_eq("bp_hold_data", 32'(if_a.o_out_data), exp_sym[rx_sym.size()]);
          end
        end
        check_eq("bp_in_ready_low", 32'(if_a.o_in_ready), 32'd0);
        check_eq("bp_credit_depth", 32'(acc_cnt - rx_sym.size()), 32'd4);
        if_a.i_out_ready = 1'b1;
      end
    join
    wait_done(1);
    check_syms("bp", 12, -1);
    check_eq("bp_len", (lena_q.size() > 0) ? lena_q[0] : 32'hFFFF_FFFF, 32'd12);

    // Overlength on the 3-bit counter instance
    clear_logs();
    send_pkt(9);
    wait_done(1);
    check_syms("ovl", 9, -1);
    check_eq("ovl_len_wide", (lena_q.size() > 0) ? lena_q[0] : 32'hFFFF_FFFF, 32'd9);
    check_eq("ovl_len_sat",  (lenb_q.size() > 0) ? lenb_q[0] : 32'hFFFF_FFFF, 32'd7);
    check_eq("ovl_err_set", 32'(err_b), 32'd1);
    check_eq("ovl_err_wide", 32'(err_a), 32'd0);

    // Single-beat packet; also clears the overlength flag
    clear_logs();
    pkt_data[0] = 8'h05;
    exp_sym[0]  = 32'hA;
    send_pkt(1);
    wait_done(1);
    check_syms("one", 1, 0);
    check_eq("one_len", (lena_q.size() > 0) ? lena_q[0] : 32'hFFFF_FFFF, 32'd1);
    check_eq("one_idle_after_done", 32'(busy_a), 32'd0);
    check_eq("ovl_err_cleared", 32'(err_b), 32'd0);

    // Reset mid-packet with two entries held in the FIFO
    clear_logs();
    if_a.i_out_ready = 1'b0;
    if_a.i_in_valid  = 1'b1;
    if_a.i_in_data   = 8'h00;
    begin
      int t;
      t = 0;
      while (wr_seen < 2 && t < 50) begin
        @(negedge clk);
        t++;
      end
      check_eq("rst_fill_seen", 32'(wr_seen), 32'd2);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    if_a.i_in_valid = 1'b0;
    #1;
    check_eq("rst_mid_outputs",
             32'({if_a.o_in_ready, if_a.o_enc_enb, if_a.o_enc_data, if_a.o_enc_rd_in,
                  if_a.o_out_valid, if_a.o_out_data, if_a.o_out_last, done_a, len_a[7:0],
                  busy_a}), 32'h0);
    @(negedge clk);
    check_eq("rst_discard_stale", 32'(if_a.o_out_valid), 32'd0);
    if_a.i_out_ready = 1'b1;
    clear_logs();
    pkt_data[0] = 8'h00; pkt_data[1] = 8'h00;
    exp_sym[0:1] = '{32'hB, 32'h4};
    send_pkt(2);
    wait_done(1);
    check_syms("post_rst", 2, -1);
    check_eq("post_rst_rd0", (rd_log.size() > 0) ? rd_log[0] : 32'hFFFF_FFFF, 32'd0);
    check_eq("post_rst_len", (lena_q.size() > 0) ? lena_q[0] : 32'hFFFF_FFFF, 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/enc_3b4b_stream_ctrl.md
Name: enc_3b4b_stream_ctrl

Overview:
- Packet sequencer between the task input buffer and the 3b4b encoder, with the output packer downstream.
- Accepts byte beats, issues the low 3 bits to the encoder and manages running disparity (RD). RD restarts at 0 on every packet and is fed back inside a packet.
- Buffers encoded nibbles in a credit-protected output FIFO, marks the last symbol, and reports packet length so the output packer needs no stream-start detection of its own.

Parameters:
PACKET_SIZE_WIDTH, 16, width of the symbol counter and of o_pkt_len
OUT_DEPTH, 4, output FIFO entries (power of 2, >=2)

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous reset, active-high
i_in_valid  in  1  input beat valid
i_in_data  in  8  input byte; only [2:0] is encoded
i_in_last  in  1  last beat of packet
o_in_ready  out  1  beat accepted when i_in_valid & o_in_ready
o_enc_data  out  3  encoder data in
o_enc_rd_in  out  1  encoder RD in
o_enc_enb  out  1  encoder enable (one symbol issued)
i_enc_data  in  4  encoder 4b symbol, 1 cycle after o_enc_enb
i_enc_rd_out  in  1  encoder RD out, aligned with i_enc_valid
i_enc_valid  in  1  encoder output valid
o_out_valid  out  1  output beat valid
o_out_data  out  8  {4'b0, symbol}
o_out_last  out  1  last symbol of packet
i_out_ready  in  1  downstream accept
o_pkt_len  out  PACKET_SIZE_WIDTH  symbols in the finished packet
o_pkt_done  out  1  1-cycle pulse; o_pkt_len valid
o_busy  out  1  state != IDLE
o_err_overlen  out  1  sticky; symbol counter saturated

Behaviour:
- Reset, including mid-packet:
  - state=IDLE, FIFO flushed, in-flight=0, RD register=0, counter=0.
  - All outputs are 0.
  - Encoder results arriving the cycle after reset are discarded.
- Encoder latency is fixed at 1 cycle. The in-flight count is 0 or 1.
- Issue: o_enc_enb = i_in_valid & o_in_ready, combinational. o_enc_data = i_in_data[2:0].
- RD:
  - First symbol of a packet: o_enc_rd_in=0.
  - Otherwise: i_enc_rd_out if i_enc_valid this cycle, else the RD register.
  - The RD register loads i_enc_rd_out on every i_enc_valid.
- A 1-bit last tag is registered alongside each issue. It is written into the FIFO with i_enc_data on i_enc_valid.
- Credit rule: issue is allowed only when fifo_count + in_flight < OUT_DEPTH. The FIFO never overflows. A write with i_enc_valid while the FIFO is full is impossible by construction; the bench asserts this.
- FIFO:
  - Output is registered: a symbol accepted at cycle t appears on o_out_valid at t+2 at the earliest.
  - Simultaneous read and write in the same cycle are both honoured.
  - o_out_data, o_out_valid and o_out_last hold stable while o_out_valid & !i_out_ready.
- FSM:
  - IDLE: o_in_ready=0. If i_in_valid, go to RUN and set the first flag. Bubble: 1 cycle per packet.
  - RUN: o_in_ready = credit ok. The first flag clears on the first issue. An accepted beat with i_in_last goes to DRAIN.
  - DRAIN: o_in_ready=0. When o_out_valid & o_out_last & i_out_ready, go to DONE.
  - DONE: o_pkt_done=1 for one cycle with o_pkt_len = counter, then go to IDLE. The counter clears in IDLE.
- Counter:
  - Increments on each FIFO write and saturates at all-ones.
  - An increment attempted at all-ones sets o_err_overlen.
  - o_err_overlen clears on the next IDLE->RUN transition.
- A single-beat packet (valid+last on the first accepted beat) goes RUN->DRAIN immediately and produces o_pkt_len=1.
- Input valid while in DRAIN/DONE is ignored (not accepted) until RUN is re-entered.

Test Plan:
- Single packet, bytes 0..7 (low 3 bits), last on 7, i_out_ready=1, encoder model standard 3b4b:
  - 8 symbols out in order with the correct RD chain starting at RD=0.
  - o_out_last only on the 8th symbol.
  - o_pkt_done with o_pkt_len=8.
  - No gaps after the first symbol.
- Two back-to-back packets (3 beats, then 2 beats): the second packet's first o_enc_rd_in=0 regardless of the first packet's final RD; o_pkt_len 3, then 2.
- Backpressure, i_out_ready=0 for 10 cycles mid-packet:
  - o_in_ready drops once the FIFO plus in-flight reach 4.
  - No symbol is lost or duplicated; the output holds stable.
  - Order is preserved after release.
- Single-beat packet: exactly 1 symbol with o_out_last=1; o_pkt_len=1; FSM back in IDLE 1 cycle after o_pkt_done.
- Overlength with PACKET_SIZE_WIDTH=3, 9 beats: o_err_overlen=1, o_pkt_len=7. The flag clears when the next packet starts.
- Reset asserted mid-packet with the FIFO holding 2 entries:
  - The next cycle has all outputs 0 and state IDLE.
  - The following packet starts with RD=0 and o_pkt_len counts from 0.
